fifo_burst_reader: RTL and testbench
====================================

Name: fifo_burst_reader

Overview:
- Read-side engine for the show-ahead push/pop FIFO. The FIFO presents head data on its output while not empty; a pop consumes that word.
- On a host request for N words, pops exactly N words as the FIFO fills and presents them on a valid/ready stream with full throughput, then pulses done.
- Sits between the FIFO's pop port and downstream consumers; replaces ad-hoc pop logic.

Parameters:
- DATA_WIDTH, 8, width of FIFO words and of the output stream.
- LEN_WIDTH, 9, width of burst length and word counter; max burst 2**LEN_WIDTH-1.

Ports:
- i_clk  input  1  clock; all state on rising edge.
- i_rst  input  1  asynchronous reset, active-high.
- i_req  input  1  start a burst; sampled only in IDLE.
- i_len  input  LEN_WIDTH  number of words to read; sampled with i_req.
- i_abort  input  1  terminate the burst in progress.
- o_fifo_pop  output  1  pop strobe to the FIFO (combinational).
- i_fifo_data  input  DATA_WIDTH  FIFO head word (show-ahead).
- i_fifo_empty  input  1  FIFO empty flag.
- o_data  output  DATA_WIDTH  stream data (registered).
- o_valid  output  1  stream valid (registered).
- i_ready  input  1  downstream ready.
- o_busy  output  1  high while in READ.
- o_done  output  1  one-cycle pulse on burst completion.
- o_count  output  LEN_WIDTH  words handed off downstream in the current/last burst.

Behaviour:
- Reset (async, any state): state=IDLE; o_data=0, o_valid=0, o_done=0, o_count=0, remaining=0. o_fifo_pop=0 while i_rst is high.
- States:
  - IDLE, READ, DONE. o_busy=1 only in READ. o_done=1 only in DONE.
- IDLE:
  - i_req=1 latches remaining=i_len and clears o_count to 0.
  - Next state is READ if i_len!=0, else DONE.
  - i_abort is ignored in IDLE.
- READ, pop condition:
  - o_fifo_pop = READ & !i_abort & remaining!=0 & !i_fifo_empty & (!o_valid | i_ready).
- READ, register updates:
  - On pop: o_data<=i_fifo_data, o_valid<=1, remaining<=remaining-1.
  - Handshake (o_valid & i_ready) without pop: o_valid<=0. With pop, o_valid stays 1, giving 1 word/cycle sustained.
  - Each handshake: o_count<=o_count+1.
- Latency: a word present at the FIFO head while o_valid=0 appears on o_data/o_valid the next cycle.
- o_data holds stable while o_valid & !i_ready. The stream never drops or duplicates a word.
- Stalls:
  - FIFO empty in READ: no pop; wait indefinitely, no timeout.
  - Downstream not ready: no pop while the output register is occupied.
- READ -> DONE when remaining==0 and (!o_valid or a handshake occurs this cycle), i.e. the last word has been accepted downstream.
- DONE lasts one cycle (o_done=1), then IDLE. i_req in DONE is ignored.
- i_abort in READ:
  - o_fifo_pop forced 0 that cycle.
  - Next cycle: IDLE, o_valid=0 (any undelivered registered word is discarded), no o_done.
  - o_count holds its value, counting only the handshake in the abort cycle if one occurs.
- i_req while busy (READ/DONE) is ignored; i_len changes mid-burst have no effect.
- Arithmetic:
  - remaining and o_count are LEN_WIDTH unsigned.
  - remaining never decrements below 0.
  - o_count never exceeds the latched length.

Test Plan:
- Length 4, FIFO preloaded with 0x11,0x22,0x33,0x44, i_ready=1 -> pops on 4 consecutive cycles; o_data 0x11..0x44 on back-to-back cycles; o_done pulses the cycle after the 0x44 handshake; o_count=4; FIFO left empty.
- Length 3, FIFO empty, words pushed at cycles 2, 9, 10 -> each word appears one cycle after it reaches the head; o_busy=1 throughout; o_done once after the third handshake.
- Length 2, FIFO holds 0xA5,0x5A, i_ready=0 for 5 cycles then 1 -> exactly one pop; o_data=0xA5 held stable 5 cycles; second pop occurs in the first ready cycle; no word lost or duplicated.
- i_len=0 with i_req -> DONE next cycle, o_done=1 for one cycle, zero pops, o_count=0.
- Length 8, i_abort after 3 handshakes with a 4th word registered and i_ready=0 -> no pop in the abort cycle; next cycle IDLE, o_valid=0, o_done never asserts, o_count=3; a new i_req (len 1) is then accepted normally.
- i_rst pulsed mid-burst (len 6 after 2 handshakes) -> all outputs 0 immediately, state IDLE; after release the FIFO head is unchanged and a new burst reads it.

Source files
------------

// File: rtl/fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader
//
// Read-side engine for a show-ahead push/pop FIFO. A host request for N words
// pops exactly N words from the FIFO as they become available and presents
// them on a valid/ready stream at up to one word per cycle, then pulses
// o_done for one cycle. An abort ends the burst early without o_done.
//
// State | Meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for i_req; latches burst length and clears o_count
// READ  | popping FIFO words into the output register and streaming them
// DONE  | one-cycle completion pulse on o_done, then back to IDLE
//
// Ports
//   i_clk, i_rst     clock (rising edge) and async active-high reset
//   i_req, i_len     burst request and length, sampled only in IDLE
//   i_abort          terminate the burst in progress (READ only)
//   o_fifo_pop       combinational pop strobe to the FIFO
//   i_fifo_data      FIFO head word (show-ahead)
//   i_fifo_empty     FIFO empty flag
//   o_data, o_valid  registered output stream
//   i_ready          downstream ready
//   o_busy           high while in READ
//   o_done           one-cycle pulse when the burst completes
//   o_count          words handed off downstream in the current/last burst
// -----------------------------------------------------------------------------
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 9
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req,
    input  logic [LEN_WIDTH-1:0]  i_len,
    input  logic                  i_abort,
    output logic                  o_fifo_pop,
    input  logic [DATA_WIDTH-1:0] i_fifo_data,
    input  logic                  i_fifo_empty,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [LEN_WIDTH-1:0]  o_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic [LEN_WIDTH-1:0]  count_q, count_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;

    logic                  in_read;
    logic                  rem_nz;
    logic                  handshake;
    logic                  pop;

    // Pop only when the output register is free or being drained this cycle,
    // so a word is never overwritten before downstream accepts it.
    always_comb begin
        in_read   = (state_q == ST_READ);
        rem_nz    = (remaining_q != '0);
        handshake = valid_q & i_ready;
        pop       = in_read & ~i_abort & rem_nz & ~i_fifo_empty
                    & (~valid_q | i_ready);
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        count_d     = count_q;
        data_d      = data_q;
        valid_d     = valid_q;

        case (state_q)
            ST_IDLE: begin
                if (i_req) begin
                    remaining_d = i_len;
                    count_d     = '0;
                    state_d     = (i_len != '0) ? ST_READ : ST_DONE;
                end
            end

            ST_READ: begin
                // A handshake in the abort cycle still counts as delivered.
                if (handshake) begin
                    count_d = count_q + LEN_WIDTH'(1);
                end

                if (i_abort) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    if (pop) begin
                        data_d      = i_fifo_data;
                        valid_d     = 1'b1;
                        remaining_d = remaining_q - LEN_WIDTH'(1);
                    end else if (handshake) begin
                        valid_d = 1'b0;
                    end

                    // Finished once everything is popped and the last word
                    // has left the output register.
                    if (!rem_nz && (!valid_q || handshake)) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            count_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            count_q     <= count_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
        end
    end

    // Gate with reset so the FIFO sees no pop while reset is held.
    assign o_fifo_pop = pop & ~i_rst;
    assign o_data     = data_q;
    assign o_valid    = valid_q;
    assign o_busy     = (state_q == ST_READ);
    assign o_done     = (state_q == ST_DONE);
    assign o_count    = count_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_burst_reader
//
// Drives fifo_burst_reader against a behavioural show-ahead FIFO. Words are
// pushed onto a scoreboard queue as they are written into the FIFO and are
// popped/compared whenever the stream hands off a word. Inputs change 1 ns
// after the rising edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_fifo_burst_reader;

    localparam int DW = 8;
    localparam int LW = 9;

    logic          clk = 1'b0;
    logic          i_rst;
    logic          i_req;
    logic [LW-1:0] i_len;
    logic          i_abort;
    logic          o_fifo_pop;
    logic [DW-1:0] i_fifo_data;
    logic          i_fifo_empty;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          i_ready;
    logic          o_busy;
    logic          o_done;
    logic [LW-1:0] o_count;

    fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_req       (i_req),
        .i_len       (i_len),
        .i_abort     (i_abort),
        .o_fifo_pop  (o_fifo_pop),
        .i_fifo_data (i_fifo_data),
        .i_fifo_empty(i_fifo_empty),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_count     (o_count)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    int            hs_cyc_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    int   cyc = 0;
    logic s_pop, s_hs, s_valid, s_done, s_busy;
    logic [DW-1:0] s_data;
    int   n_pops, n_hs, n_done;
    int   first_pop, last_pop, first_hs, last_hs, done_cyc;

    typedef struct {
        logic [LW-1:0] len;
        int            nwords;
        logic [7:0]    ready_mask;
        int            exp_count;
        int            exp_left;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic refresh();
        i_fifo_empty = (fifo_q.size() == 0);
        i_fifo_data  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
    endtask

    task automatic push(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        refresh();
    endtask

    task automatic clear();
        fifo_q.delete();
        exp_q.delete();
        refresh();
    endtask

    task automatic start_stats();
        n_pops = 0; n_hs = 0; n_done = 0;
        first_pop = -1; last_pop = -1; first_hs = -1; last_hs = -1; done_cyc = -1;
        hs_cyc_q.delete();
    endtask

    task automatic tick();
        logic [DW-1:0] e;
        logic [DW-1:0] tmp;
        @(negedge clk);
        cyc++;
        s_pop   = o_fifo_pop;
        s_hs    = o_valid & i_ready;
        s_valid = o_valid;
        s_data  = o_data;
        s_done  = o_done;
        s_busy  = o_busy;
        if (s_pop) begin
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
            n_pops++;
        end
        if (s_done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (s_hs) begin
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
            n_hs++;
            hs_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("sb_extra_word", 32'(s_data), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("sb_data", 32'(s_data), 32'(e));
            end
        end
        @(posedge clk);
        #1;
        if (s_pop) begin
            check("pop_not_empty", 32'(fifo_q.size() != 0), 32'd1);
            if (fifo_q.size() != 0) tmp = fifo_q.pop_front();
        end
        refresh();
    endtask

    task automatic run_until_done(input int bound);
        for (int k = 0; k < bound; k++) begin
            tick();
            if (s_done) break;
        end
        check("done_seen", 32'(s_done), 32'd1);
    endtask

    initial begin
        logic [DW-1:0] drop;
        int push_cyc[$];
        logic busy_ok, stable_ok;

        vecs[0] = '{len: 9'd4, nwords: 4, ready_mask: 8'hFF,       exp_count: 4, exp_left: 0};
        vecs[1] = '{len: 9'd1, nwords: 3, ready_mask: 8'hFF,       exp_count: 1, exp_left: 2};
        vecs[2] = '{len: 9'd5, nwords: 5, ready_mask: 8'b10110010, exp_count: 5, exp_left: 0};
        vecs[3] = '{len: 9'd0, nwords: 2, ready_mask: 8'hFF,       exp_count: 0, exp_left: 2};
        vecs[4] = '{len: 9'd7, nwords: 9, ready_mask: 8'b01010101, exp_count: 7, exp_left: 2};
        vecs[5] = '{len: 9'd3, nwords: 3, ready_mask: 8'b00000001, exp_count: 3, exp_left: 0};

        i_rst = 1'b1; i_req = 1'b0; i_len = '0; i_abort = 1'b0; i_ready = 1'b0;
        clear();
        start_stats();

        // Reset state
        #12;
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_data",  32'(o_data),  32'd0);
        check("rst_count", 32'(o_count), 32'd0);
        check("rst_busy",  32'(o_busy),  32'd0);
        check("rst_done",  32'(o_done),  32'd0);
        check("rst_pop",   32'(o_fifo_pop), 32'd0);
        @(posedge clk); #1;
        i_rst = 1'b0;
        tick();

        // Length 4, preloaded, full throughput
        clear();
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        start_stats();
        i_ready = 1'b1; i_req = 1'b1; i_len = 9'd4;
        tick();
        i_req = 1'b0;
        run_until_done(20);
        check("s1_pops",      32'(n_pops), 32'd4);
        check("s1_pop_span",  32'(last_pop - first_pop), 32'd3);
        check("s1_hs",        32'(n_hs), 32'd4);
        check("s1_hs_span",   32'(last_hs - first_hs), 32'd3);
        check("s1_latency",   32'(first_hs - first_pop), 32'd1);
        check("s1_done_when", 32'(done_cyc - last_hs), 32'd1);
        check("s1_count",     32'(o_count), 32'd4);
        check("s1_fifo_left", 32'(fifo_q.size()), 32'd0);
        tick();
        check("s1_done_once", 32'(n_done), 32'd1);
        check("s1_idle",      32'(s_busy), 32'd0);

        // Length 3, empty FIFO, words arrive late
        clear();
        start_stats();
        push_cyc.delete();
        i_ready = 1'b1; i_req = 1'b1; i_len = 9'd3;
        tick();
        i_req = 1'b0;
        busy_ok = 1'b1;
        for (int c = 0; c < 40 && !s_done; c++) begin
            if (c == 2 || c == 9 || c == 10) begin
                push(8'h30 + 8'(c));
                push_cyc.push_back(cyc + 1);
            end
            tick();
            if (!s_done && !s_busy) busy_ok = 1'b0;
        end
        check("s2_done_seen", 32'(s_done), 32'd1);
        check("s2_busy_held", 32'(busy_ok), 32'd1);
        check("s2_hs",        32'(n_hs), 32'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < hs_cyc_q.size() && k < push_cyc.size())
                check("s2_latency", 32'(hs_cyc_q[k] - push_cyc[k]), 32'd1);
            else
                check("s2_latency_missing", 32'(hs_cyc_q.size()), 32'd3);
        end
        check("s2_done_after", 32'(done_cyc - last_hs), 32'd1);
        tick();
        check("s2_done_once", 32'(n_done), 32'd1);
        check("s2_count",     32'(o_count), 32'd3);

        // Length 2, downstream stalled for 5 cycles
        clear();
        push(8'hA5); push(8'h5A);
        start_stats();
        i_ready = 1'b0; i_req = 1'b1; i_len = 9'd2;
        tick();
        i_req = 1'b0;
        stable_ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k > 0 && (!s_valid || s_data != 8'hA5)) stable_ok = 1'b0;
        end
        check("s3_one_pop",  32'(n_pops), 32'd1);
        check("s3_stable",   32'(stable_ok), 32'd1);
        i_ready = 1'b1;
        tick();
        check("s3_pop_on_ready", 32'(s_pop), 32'd1);
        check("s3_hs_on_ready",  32'(s_hs), 32'd1);
        run_until_done(10);
        check("s3_pops",   32'(n_pops), 32'd2);
        check("s3_hs",     32'(n_hs), 32'd2);
        check("s3_sb_empty", 32'(exp_q.size()), 32'd0);

        // Zero length
        clear();
        push(8'h77);
        start_stats();
        i_req = 1'b1; i_len = 9'd0;
        tick();
        i_req = 1'b0;
        tick();
        check("s4_done",  32'(s_done), 32'd1);
        check("s4_busy",  32'(s_busy), 32'd0);
        tick();
        check("s4_done_pulse", 32'(s_done), 32'd0);
        check("s4_pops",  32'(n_pops), 32'd0);
        check("s4_count", 32'(o_count), 32'd0);
        check("s4_fifo",  32'(fifo_q.size()), 32'd1);

        // Abort with a registered, undelivered word
        clear();
        for (int k = 0; k < 8; k++) push(8'h80 + 8'(k));
        start_stats();
        i_ready = 1'b1; i_req = 1'b1; i_len = 9'd8;
        tick();
        i_req = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("s5_hs_before", 32'(n_hs), 32'd3);
        i_ready = 1'b0; i_abort = 1'b1;
        tick();
        check("s5_abort_pop", 32'(s_pop), 32'd0);
        i_abort = 1'b0;
        tick();
        check("s5_idle",  32'(s_busy), 32'd0);
        check("s5_valid", 32'(s_valid), 32'd0);
        check("s5_count", 32'(o_count), 32'd3);
        drop = exp_q.pop_front();
        tick(); tick();
        check("s5_no_done", 32'(n_done), 32'd0);
        start_stats();
        i_ready = 1'b1; i_req = 1'b1; i_len = 9'd1;
        tick();
        i_req = 1'b0;
        run_until_done(10);
        check("s5_new_count", 32'(o_count), 32'd1);
        check("s5_new_hs",    32'(n_hs), 32'd1);

        // Reset mid-burst
        clear();
        for (int k = 0; k < 6; k++) push(8'h60 + 8'(k));
        start_stats();
        i_ready = 1'b1; i_req = 1'b1; i_len = 9'd6;
        tick();
        i_req = 1'b0;
        tick(); tick(); tick();
        check("s6_count_pre", 32'(o_count), 32'd2);
        i_rst = 1'b1;
        #1;
        check("s6_rst_valid", 32'(o_valid), 32'd0);
        check("s6_rst_data",  32'(o_data),  32'd0);
        check("s6_rst_count", 32'(o_count), 32'd0);
        check("s6_rst_busy",  32'(o_busy),  32'd0);
        check("s6_rst_pop",   32'(o_fifo_pop), 32'd0);
        tick(); tick();
        check("s6_head", 32'(i_fifo_data), 32'h63);
        check("s6_fifo_size", 32'(fifo_q.size()), 32'd3);
        i_rst = 1'b0;
        drop = exp_q.pop_front();
        start_stats();
        i_req = 1'b1; i_len = 9'd1;
        tick();
        i_req = 1'b0;
        run_until_done(10);
        check("s6_new_count", 32'(o_count), 32'd1);
        check("s6_new_hs",    32'(n_hs), 32'd1);

        // Table-driven bursts with varying ready patterns
        foreach (vecs[i]) begin
            clear();
            for (int w = 0; w < vecs[i].nwords; w++) push(8'($urandom_range(0, 255)));
            start_stats();
            i_ready = 1'b1; i_req = 1'b1; i_len = vecs[i].len;
            tick();
            i_req = 1'b0;
            for (int k = 0; k < 300 && !s_done; k++) begin
                i_ready = vecs[i].ready_mask[k % 8];
                tick();
            end
            check("vec_done",  32'(s_done), 32'd1);
            check("vec_pops",  32'(n_pops), 32'(vecs[i].exp_count));
            check("vec_count", 32'(o_count), 32'(vecs[i].exp_count));
            check("vec_left",  32'(fifo_q.size()), 32'(vecs[i].exp_left));
            i_ready = 1'b1;
            tick();
            check("vec_done_once", 32'(n_done), 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
